// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift unit.
//   mode_e  : shift mode encodings as presented on the mode port
//   FLAG_*  : bit positions inside the {negative, zero, carry} flag vector
//   state_e : control FSM states
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_ASR = 2'b01,
        MODE_LSL = 2'b10,
        MODE_ROR = 2'b11
    } mode_e;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/shift_step.sv
// One-position shift step, purely combinational.
//   word_i : current working word
//   mode_i : LSR / ASR / LSL / ROR
//   fill_i : bit inserted by the logical shifts (ignored by ASR / ROR)
//   word_o : word after one step
//   bit_o  : bit that leaves the word in this step
module shift_step
    import shift_pkg::*;
#(
    parameter int ancho = 8
) (
    input  logic [ancho-1:0] word_i,
    input  mode_e            mode_i,
    input  logic             fill_i,
    output logic [ancho-1:0] word_o,
    output logic             bit_o
);

    always_comb begin
        word_o = word_i;
        bit_o  = 1'b0;
        unique case (mode_i)
            MODE_LSR: begin
                word_o = {fill_i, word_i[ancho-1:1]};
                bit_o  = word_i[0];
            end
            MODE_ASR: begin
                word_o = {word_i[ancho-1], word_i[ancho-1:1]};
                bit_o  = word_i[0];
            end
            MODE_LSL: begin
                word_o = {word_i[ancho-2:0], fill_i};
                bit_o  = word_i[ancho-1];
            end
            MODE_ROR: begin
                word_o = {word_i[0], word_i[ancho-1:1]};
                bit_o  = word_i[0];
            end
            default: begin
                word_o = word_i;
                bit_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift unit: one bit position per clock.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake (a, b, mode, aluflagin)
//   a                    : operand, b : unsigned shift amount
//   mode                 : 00 LSR, 01 ASR, 10 LSL, 11 ROR
//   aluflagin            : fill bit for LSR / LSL
//   out_valid / out_ready: result handshake
//   aluresult            : shifted result (registered)
//   aluflags             : {negative, zero, carry}
module seq_shifter
    import shift_pkg::*;
#(
    parameter int ancho = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ancho-1:0] a,
    input  logic [ancho-1:0] b,
    input  logic [1:0]       mode,
    input  logic             aluflagin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ancho-1:0] aluresult,
    output logic [2:0]       aluflags
);

    localparam int CW = $clog2(ancho) + 1;
    localparam logic [ancho-1:0] ANCHO_B = ancho'(ancho);

    state_e           state_q, state_d;
    logic [ancho-1:0] work_q;
    logic [2:0]       flags_q;
    logic [CW-1:0]    cnt_q;
    mode_e            mode_q;
    logic             fill_q;

    logic [ancho-1:0] step_word;
    logic             step_bit;
    logic [CW-1:0]    cnt_init;

    shift_step #(
        .ancho(ancho)
    ) u_step (
        .word_i(work_q),
        .mode_i(mode_q),
        .fill_i(fill_q),
        .word_o(step_word),
        .bit_o (step_bit)
    );

    // Rotation wraps modulo the width; the other modes saturate at the width,
    // which already yields all-fill / all-sign with the correct last carry.
    always_comb begin
        cnt_init = '0;
        if (mode_e'(mode) == MODE_ROR) begin
            cnt_init = CW'(b % ANCHO_B);
        end else if (b >= ANCHO_B) begin
            cnt_init = CW'(ancho);
        end else begin
            cnt_init = CW'(b);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (in_valid)      state_d = ST_SHIFT;
            ST_SHIFT: if (cnt_q == '0)   state_d = ST_DONE;
            ST_DONE:  if (out_ready)     state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            work_q  <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_LSR;
            fill_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_q          <= a;
                        mode_q          <= mode_e'(mode);
                        fill_q          <= aluflagin;
                        cnt_q           <= cnt_init;
                        flags_q[FLAG_C] <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == '0) begin
                        flags_q[FLAG_N] <= work_q[ancho-1];
                        flags_q[FLAG_Z] <= (work_q == '0);
                    end else begin
                        work_q          <= step_word;
                        flags_q[FLAG_C] <= step_bit;
                        cnt_q           <= cnt_q - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign aluresult = work_q;
    assign aluflags  = flags_q;

endmodule

// File: doc/seq_shifter.md
Name: seq_shifter

Overview:
Multi-cycle, parametrised shift unit for the ALU datapath. It accepts operand `a` and shift amount `b` through a valid/ready handshake and shifts one bit position per clock. It supports four modes: logical right, arithmetic right, logical left and rotate right. Logical shifts take a selectable fill bit. The result and a {negative, zero, carry} flag vector are presented on an output valid/ready handshake.

Parameters:
ancho, 8, data width of a, b and aluresult; must be >= 2
CW, $clog2(ancho)+1, shift-counter width (derived; not overridable)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset; synchronous, active-high
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
a  input  ancho  operand to shift
b  input  ancho  shift amount, unsigned
mode  input  2  00 LSR, 01 ASR, 10 LSL, 11 ROR
aluflagin  input  1  fill bit for LSR/LSL; ignored for ASR/ROR
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
aluresult  output  ancho  shifted result (registered)
aluflags  output  3  [2]=negative (aluresult MSB), [1]=zero, [0]=carry (last bit shifted out)

Behaviour:
- States: IDLE, SHIFT, DONE. Reset (rst=1 at an edge) forces IDLE, aluresult=0, aluflags=0, out_valid=0, counter=0.
- Reset takes priority over all other events, including mid-SHIFT and DONE. Any in-flight operation is discarded with no output.
- in_ready = (state==IDLE). out_valid = (state==DONE). Both are decoded from state only, with no combinational input-to-output path.
- IDLE: accept when in_valid & in_ready at an edge.
  - Latch a into the working register; latch mode and fill.
  - Carry := 0.
  - Counter n := min(b, ancho) for LSR/ASR/LSL; n := b mod ancho for ROR.
  - Go to SHIFT.
- SHIFT, per edge:
  - If n==0, go to DONE, and compute zero and negative from the working register.
  - Otherwise perform a one-position step and n := n-1:
    - LSR: MSB := fill.
    - ASR: MSB := old MSB.
    - LSL: LSB := fill.
    - ROR: MSB := old LSB.
  - Carry := the bit leaving (LSB for right modes and ROR, MSB for LSL).
- Latency: out_valid is first high after edge k+n+1, where edge k is the accept edge. For b=0, result = a, carry = 0, latency 1.
- DONE: aluresult and aluflags hold stable while out_valid=1 and out_ready=0. On the edge with out_ready=1, go to IDLE.
  - The next request can be accepted no earlier than the edge after leaving DONE; there is no same-cycle turnaround.
- Saturation: b >= ancho in LSR/LSL gives all-fill. In ASR it gives all copies of the sign bit. Carry is the last bit shifted out: a[ancho-1] for LSR/ASR, a[0] for LSL.
- in_valid, a, b and mode are ignored outside IDLE. Inputs need not be held after acceptance.
- aluresult/aluflags keep their last value in IDLE. They are meaningful only while out_valid=1.

Decomposition:
- Package shift_pkg:
  - mode encodings (LSR, ASR, LSL, ROR)
  - flag bit indices (FLAG_N=2, FLAG_Z=1, FLAG_C=0)
  - state enum (IDLE, SHIFT, DONE)
- Sub-module shift_step (combinational, parametrised by ancho): inputs are word, mode and fill; outputs are next word and bit out. It is instantiated once inside seq_shifter.
- Control FSM, counter and registers stay in seq_shifter.

Test Plan:
- LSR, fill=0, a=8'hB2, b=3, out_ready=1 → aluresult=8'h16, flags N=0/Z=0/C=0; out_valid rises 4 cycles after accept, in_ready=0 meanwhile.
- ASR, a=8'hB2, b=3 → 8'hF6, N=1, C=0. LSR fill=1, a=8'h00, b=4 → 8'hF0, C=0.
- ROR, a=8'h81, b=9 (effective 1) → 8'hC0, C=1, latency 2. LSL, fill=0, a=8'h81, b=200 (clamped 8) → 8'h00, Z=1, C=1, latency 9.
- b=0, any mode, a=8'h5A → 8'h5A, C=0, latency 1. Hold out_ready=0 for 5 cycles: out_valid, aluresult and aluflags remain stable, in_ready=0, and a new in_valid is ignored.
- Assert rst=1 during the third SHIFT cycle of an LSL b=6 → next cycle shows IDLE, in_ready=1, out_valid=0, aluresult=0, aluflags=0. A following request completes correctly.
- Back-to-back: two requests with in_valid held high → second is accepted only on the edge after the first result is consumed. Both results are correct; none is lost or duplicated.
